// File: rtl/cram_arbiter.sv
// Cart-RAM arbiter: the mapper CPU owns the single RAM port whenever it
// accesses it, and the save port borrows the cycles the CPU leaves free.
module cram_arbiter #(
    parameter int          ADDR_W     = 17,
    parameter logic [15:0] DIRTY_HOLD = 16'd32768
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_32k,
    input  logic              has_ram,
    input  logic [3:0]        ram_mask,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              sv_req,
    input  logic              sv_we,
    input  logic [ADDR_W-1:0] sv_addr,
    input  logic [7:0]        sv_wdata,
    output logic              sv_ack,
    output logic [7:0]        sv_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              dirty,
    input  logic              dirty_clear,
    output logic              dirty_settled
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RETURN} sv_state_t;

    sv_state_t         state, state_nx;
    logic              cpu_acc, sv_drive;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q, cpu_rdata_q, sv_rdata_q;
    logic              rd_pend, sv_is_rd;
    logic [15:0]       settle_cnt;
    logic [7:0]        rd_val;

    function automatic logic [ADDR_W-1:0] mask_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [3:0] m);
        logic [ADDR_W-1:0] r;
        r        = a;
        r[16:13] = a[16:13] & m;
        return r;
    endfunction

    assign cpu_acc = cpu_rd | cpu_wr;
    assign rd_val  = has_ram ? ram_rdata : 8'hFF;

    always_ff @(posedge clk_sys) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (sv_req && !sv_ack) state_nx = S_ISSUE;
            // a dropped request abandons the access without an ack
            S_ISSUE:  if (!sv_req)      state_nx = S_IDLE;
                      else if (!cpu_acc) state_nx = S_RETURN;
            S_RETURN: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        sv_ack    = (state == S_RETURN);
        sv_drive  = (state == S_ISSUE) && sv_req && !cpu_acc;
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        ram_wdata = wdata_q;
        if (cpu_acc) begin
            ram_addr = mask_addr(cpu_addr, ram_mask);
            ram_we   = cpu_wr & has_ram;
            if (cpu_wr) ram_wdata = cpu_wdata;
        end else if (sv_drive) begin
            ram_addr = mask_addr(sv_addr, ram_mask);
            ram_we   = sv_we & has_ram;
            if (sv_we) ram_wdata = sv_wdata;
        end
    end

    // Read data is passed through in the cycle it arrives, then held.
    assign cpu_rdata     = rd_pend ? rd_val : cpu_rdata_q;
    assign sv_rdata      = (sv_ack && sv_is_rd) ? rd_val : sv_rdata_q;
    assign dirty_settled = dirty && (settle_cnt == DIRTY_HOLD);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= 8'hFF;
            sv_rdata_q  <= 8'hFF;
            rd_pend     <= 1'b0;
            sv_is_rd    <= 1'b0;
            dirty       <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
            rd_pend <= cpu_rd;
            if (rd_pend)            cpu_rdata_q <= rd_val;
            if (sv_drive)           sv_is_rd    <= !sv_we;
            if (sv_ack && sv_is_rd) sv_rdata_q  <= rd_val;

            if (dirty_clear)           dirty <= 1'b0;
            else if (cpu_wr && has_ram) dirty <= 1'b1;

            if (dirty_clear || cpu_wr)
                settle_cnt <= '0;
            else if (ce_32k && dirty && settle_cnt != DIRTY_HOLD)
                settle_cnt <= settle_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cram_arbiter.sv
// Directed bench for cram_arbiter with a one-cycle-latency RAM model.
module tb_cram_arbiter;

    localparam int AW = 17;

    logic          clk_sys = 1'b0;
    logic          reset, ce_32k, has_ram;
    logic [3:0]    ram_mask;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic          sv_req, sv_we, sv_ack;
    logic [AW-1:0] sv_addr;
    logic [7:0]    sv_wdata, sv_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata, ram_rdata;
    logic          dirty, dirty_clear, dirty_settled;

    logic [7:0] mem [0:(1<<AW)-1];
    int checks = 0;
    int errors = 0;

    cram_arbiter #(.ADDR_W(AW), .DIRTY_HOLD(16'd4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_32k(ce_32k), .has_ram(has_ram),
        .ram_mask(ram_mask), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .sv_req(sv_req), .sv_we(sv_we),
        .sv_addr(sv_addr), .sv_wdata(sv_wdata), .sv_ack(sv_ack), .sv_rdata(sv_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dirty(dirty), .dirty_clear(dirty_clear), .dirty_settled(dirty_settled)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs are then driven at +1 and outputs sampled at +3
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic reset_outs(input string pfx);
        chk({pfx, "_ack"},   32'(sv_ack), 0);
        chk({pfx, "_we"},    32'(ram_we), 0);
        chk({pfx, "_addr"},  32'(ram_addr), 0);
        chk({pfx, "_wdata"}, 32'(ram_wdata), 0);
        chk({pfx, "_crd"},   32'(cpu_rdata), 32'hFF);
        chk({pfx, "_srd"},   32'(sv_rdata), 32'hFF);
        chk({pfx, "_dirty"}, 32'(dirty), 0);
        chk({pfx, "_sett"},  32'(dirty_settled), 0);
    endtask

    initial begin
        reset = 1; ce_32k = 0; has_ram = 1; ram_mask = 4'hF;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        sv_req = 0; sv_we = 0; sv_addr = '0; sv_wdata = '0; dirty_clear = 0;
        tick(); tick();
        settle();
        reset_outs("rst");
        reset = 0;

        // preload RAM[0x123] through the CPU port
        tick(); cpu_wr = 1; cpu_addr = 17'h00123; cpu_wdata = 8'h5A;
        tick(); cpu_wr = 0; settle();
        chk("pre_dirty", 32'(dirty), 1);

        // save read, no CPU traffic: ack two cycles after request
        tick(); sv_req = 1; sv_we = 0; sv_addr = 17'h00123; settle();
        chk("rd_ack_n", 32'(sv_ack), 0);
        tick(); settle();
        chk("rd_ack_n1", 32'(sv_ack), 0);
        chk("rd_addr", 32'(ram_addr), 32'h00123);
        chk("rd_we", 32'(ram_we), 0);
        tick(); settle();
        chk("rd_ack_n2", 32'(sv_ack), 1);
        chk("rd_data", 32'(sv_rdata), 32'h5A);
        sv_req = 0;
        tick(); settle();
        chk("rd_ack_off", 32'(sv_ack), 0);
        chk("rd_hold", 32'(sv_rdata), 32'h5A);
        chk("idle_addr", 32'(ram_addr), 32'h00123);

        // bank mask on a CPU write
        ram_mask = 4'b0001; cpu_wr = 1; cpu_addr = 17'h1E000; cpu_wdata = 8'h77; settle();
        chk("mask_addr", 32'(ram_addr), 32'h02000);
        chk("mask_we", 32'(ram_we), 1);
        chk("mask_wd", 32'(ram_wdata), 32'h77);
        tick(); cpu_wr = 0; ram_mask = 4'hF;
        cpu_rd = 1; cpu_addr = 17'h02000;
        tick(); cpu_rd = 0;
        tick(); settle();
        chk("cpu_rdata", 32'(cpu_rdata), 32'h77);

        // save write blocked by three CPU writes
        sv_req = 1; sv_we = 1; sv_addr = 17'h00456; sv_wdata = 8'hA5;
        tick();
        for (int i = 0; i < 3; i++) begin
            cpu_wr = 1; cpu_addr = AW'(17'h10 + i); cpu_wdata = 8'(8'h11 * (i + 1)); settle();
            chk("blk_addr", 32'(ram_addr), 32'h10 + i);
            chk("blk_ack", 32'(sv_ack), 0);
            tick();
        end
        cpu_wr = 0; settle();
        chk("iss4_addr", 32'(ram_addr), 32'h00456);
        chk("iss4_we", 32'(ram_we), 1);
        chk("iss4_wd", 32'(ram_wdata), 32'hA5);
        chk("iss4_ack", 32'(sv_ack), 0);
        tick(); settle();
        chk("ack5", 32'(sv_ack), 1);
        sv_req = 0;
        tick(); settle();
        chk("mem_10", 32'(mem[17'h10]), 32'h11);
        chk("mem_12", 32'(mem[17'h12]), 32'h33);
        chk("mem_456", 32'(mem[17'h456]), 32'hA5);

        // dirty settle with DIRTY_HOLD=4
        dirty_clear = 1; tick(); dirty_clear = 0; settle();
        chk("clr_dirty", 32'(dirty), 0);
        // a save write must not set dirty
        sv_req = 1; sv_we = 1; sv_addr = 17'h00500; sv_wdata = 8'h01;
        tick(); tick(); settle();
        chk("svw_ack", 32'(sv_ack), 1);
        sv_req = 0; tick(); settle();
        chk("svw_dirty", 32'(dirty), 0);
        cpu_wr = 1; cpu_addr = 17'h20; cpu_wdata = 8'h01;
        tick(); cpu_wr = 0;
        for (int i = 1; i <= 6; i++) begin
            ce_32k = 1; tick(); ce_32k = 0; settle();
            chk($sformatf("settle_%0d", i), 32'(dirty_settled), (i >= 4) ? 1 : 0);
            tick();
        end
        dirty_clear = 1; cpu_wr = 1; cpu_addr = 17'h21;
        tick(); dirty_clear = 0; cpu_wr = 0; settle();
        chk("clrwr_dirty", 32'(dirty), 0);
        chk("clrwr_sett", 32'(dirty_settled), 0);

        // request dropped in ISSUE: no access, no ack
        sv_req = 1; sv_we = 1; sv_addr = 17'h00777; sv_wdata = 8'hEE;
        tick(); sv_req = 0; settle();
        chk("drop_we", 32'(ram_we), 0);
        tick(); settle();
        chk("drop_ack1", 32'(sv_ack), 0);
        tick(); settle();
        chk("drop_ack2", 32'(sv_ack), 0);

        // no external RAM
        has_ram = 0;
        sv_req = 1; sv_we = 0; sv_addr = 17'h00123;
        tick(); settle();
        chk("nr_we", 32'(ram_we), 0);
        tick(); settle();
        chk("nr_ack", 32'(sv_ack), 1);
        chk("nr_srd", 32'(sv_rdata), 32'hFF);
        sv_req = 0;
        cpu_wr = 1; cpu_addr = 17'h00123; cpu_wdata = 8'h00; settle();
        chk("nr_cpuwe", 32'(ram_we), 0);
        tick(); cpu_wr = 0; cpu_rd = 1;
        tick(); cpu_rd = 0;
        tick(); settle();
        chk("nr_crd", 32'(cpu_rdata), 32'hFF);
        chk("nr_dirty", 32'(dirty), 0);
        has_ram = 1;

        // reset mid-transaction
        sv_req = 1; sv_we = 0; sv_addr = 17'h00123;
        tick(); reset = 1; sv_req = 0;
        tick(); settle();
        reset_outs("mrst");
        reset = 0;
        tick(); settle();
        chk("mrst_ack2", 32'(sv_ack), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cram_arbiter.md
CRAM_ARBITER -- requirements
Module: cram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 17, cart-RAM byte address width.
REQ-002 Parameter: DIRTY_HOLD, 16'd32768, ce_32k ticks of write silence before dirty_settled asserts (about 1 s).
REQ-003 Port: clk_sys  in  1  system clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: ce_32k  in  1  32 kHz clock-enable pulse.
REQ-006 Port: has_ram  in  1  cart has external RAM.
REQ-007 Port: ram_mask  in  4  8 KB bank mask; masks addr[16:13] for both requesters.
REQ-008 Port: cpu_rd  in  1  mapper read strobe; one-cycle pulse.
REQ-009 Port: cpu_wr  in  1  mapper write strobe; one-cycle pulse.
REQ-010 Port: cpu_addr  in  ADDR_W  mapper address.
REQ-011 Port: cpu_wdata  in  8  mapper write data.
REQ-012 Port: cpu_rdata  out  8  mapper read data, held until the next CPU read completes.
REQ-013 Port: sv_req  in  1  save-port request level; held until sv_ack.
REQ-014 Port: sv_we  in  1  save-port write (1) or read (0); stable while sv_req is high.
REQ-015 Port: sv_addr  in  ADDR_W  save-port address; stable while sv_req is high.
REQ-016 Port: sv_wdata  in  8  save-port write data; stable while sv_req is high.
REQ-017 Port: sv_ack  out  1  one-cycle completion pulse.
REQ-018 Port: sv_rdata  out  8  save-port read data; valid in the sv_ack cycle and held afterwards.
REQ-019 Port: ram_addr  out  ADDR_W  RAM address.
REQ-020 Port: ram_we  out  1  RAM write enable.
REQ-021 Port: ram_wdata  out  8  RAM write data.
REQ-022 Port: ram_rdata  in  8  RAM read data; valid one cycle after the address is presented.
REQ-023 Port: dirty  out  1  CPU has written RAM since the last clear.
REQ-024 Port: dirty_clear  in  1  clears dirty and the settle counter.
REQ-025 Port: dirty_settled  out  1  dirty and no CPU write for DIRTY_HOLD ticks.

Function
REQ-026 Single-port RAM is shared; the CPU has absolute priority and is never stalled.
REQ-027 CPU access (cpu_rd or cpu_wr) drives the RAM port combinationally in the same cycle: ram_addr = masked cpu_addr; ram_we = cpu_wr & has_ram.
REQ-028 cpu_rdata <= ram_rdata one cycle after cpu_rd; if has_ram=0, cpu_rdata <= 8'hFF.
REQ-029 Save FSM states: IDLE, ISSUE, RETURN.
REQ-030 IDLE -> ISSUE when sv_req=1 and sv_ack=0.
REQ-031 In ISSUE with no CPU access: the RAM port carries the save access (ram_we = sv_we & has_ram); next state is RETURN.
REQ-032 In ISSUE with a CPU access: the save access is not driven; the FSM stays in ISSUE.
REQ-033 In RETURN: sv_ack=1; sv_rdata <= ram_rdata for reads, or 8'hFF if has_ram=0; next state is IDLE.
REQ-034 After the ack, at least one IDLE cycle separates it from the next acceptance.
REQ-035 Save latency with no CPU traffic: sv_req rise at cycle N, sv_ack at N+2.
REQ-036 Address mask: masked addr[16:13] = addr[16:13] & ram_mask; addr[12:0] passes unchanged.
REQ-037 When idle, ram_we=0 and ram_addr holds its last value.
REQ-038 dirty sets on any cpu_wr with has_ram=1.
REQ-039 A save-port write does not set dirty.
REQ-040 dirty_clear has priority over a same-cycle cpu_wr; dirty ends 0.
REQ-041 Settle counter: reset to 0 on cpu_wr or dirty_clear.
REQ-042 Settle counter: on ce_32k, increments while dirty=1, saturating at DIRTY_HOLD.
REQ-043 dirty_settled = dirty & (counter == DIRTY_HOLD).
REQ-044 sv_req dropped while in ISSUE (protocol violation): return to IDLE with no ack.

Reset
REQ-045 On reset: FSM=IDLE; sv_ack=0; ram_we=0; ram_addr=0; ram_wdata=0; cpu_rdata=8'hFF; sv_rdata=8'hFF; dirty=0; settle counter=0; dirty_settled=0.
REQ-046 Reset mid-transaction aborts it with no ack; the requester must re-raise sv_req.

Verification
REQ-047 Save read 0x00123, no CPU traffic, RAM[0x00123]=0x5A -> sv_ack 2 cycles after the sv_req rise; sv_rdata=0x5A.
REQ-048 cpu_wr in the save access's ISSUE cycles for 3 consecutive cycles -> CPU writes land; save access issues on the 4th cycle, ack on the 5th.
REQ-049 ram_mask=4'b0001, CPU write 0x1E000 data 0x77 -> ram_addr=0x02000, ram_we=1.
REQ-050 has_ram=0, save read -> ack with sv_rdata=0xFF, ram_we never 1; cpu_rd -> cpu_rdata=0xFF.
REQ-051 DIRTY_HOLD=4, CPU write then 4 ce_32k pulses -> dirty_settled=1; dirty_clear together with cpu_wr -> dirty=0, dirty_settled=0.
REQ-052 Reset asserted in ISSUE -> no sv_ack; all outputs at REQ-045 values the next cycle.
